// File: rtl/latch_shreg_2ph_multi.sv
// Multi-lane latch-based shift register clocked by an internally generated,
// programmable, non-overlapping two-phase clock (phi1 = even stages, phi2 = odd).
module latch_shreg_2ph_multi #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 64,
    parameter int DIV_W = 8,
    localparam int HALF  = DEPTH / 2,
    localparam int TAP_W = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic [DIV_W-1:0] div,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] dout,
    output logic             phi1,
    output logic             phi2,
    output logic             busy,
    output logic             shift_done
);

    if (DEPTH < 2 || (DEPTH % 2) != 0) begin : g_bad_depth
        $error("latch_shreg_2ph_multi: DEPTH must be even and >= 2");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        G1   = 3'd2,
        P2   = 3'd3,
        G2   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_q;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   din_q;
    logic               load;
    logic               hold_d;
    logic               phi1_d;
    logic               phi2_d;
    logic               done_d;
    logic [TAP_W-1:0]   tap;

    // State register; phases and strobe are registered so no decode glitch reaches the latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            div_q      <= '0;
            mode_q     <= '0;
            din_q      <= '0;
            phi1       <= 1'b0;
            phi2       <= 1'b0;
            shift_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= (state_d != state) ? '0 : cnt + 1'b1;
            phi1       <= phi1_d;
            phi2       <= phi2_d;
            shift_done <= done_d;
            if (load) begin
                div_q  <= div;
                mode_q <= mode;
                din_q  <= din;
            end
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (en) state_d = P1;
            P1:      if (cnt == div_q) state_d = G1;
            G1:      state_d = P2;
            P2:      if (cnt == div_q) state_d = G2;
            G2:      state_d = en ? P1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // On P1 entry the incoming mode decides the cycle; afterwards the captured copy does
    always_comb begin
        load   = (state_d == P1) && (state != P1);
        hold_d = load ? mode[1] : mode_q[1];
        phi1_d = (state_d == P1) && !hold_d;
        phi2_d = (state_d == P2) && !hold_d;
        done_d = (state_d == G2) && !hold_d;
    end

    assign busy = (state != IDLE);

    if (HALF == (1 << TAP_W)) begin : g_tap_full
        assign tap = tap_sel;
    end else begin : g_tap_clamp
        assign tap = (int'(tap_sel) > HALF - 1) ? TAP_W'(HALF - 1) : tap_sel;
    end

    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        logic [HALF-1:0] ev;
        logic [HALF-1:0] od;
        logic [HALF-1:0] ev_d;
        logic            s0;

        // Tap is an odd stage, closed during phi1, so recirculation has no loop
        assign s0      = mode_q[0] ? od[tap] : din_q[l];
        assign dout[l] = od[tap];

        if (HALF > 1) begin : g_chain
            assign ev_d = {od[HALF-2:0], s0};
        end else begin : g_single
            assign ev_d = s0;
        end

        always_latch begin
            if (!rst_n)
                ev <= '0;
            else if (phi1)
                ev <= ev_d;
        end

        always_latch begin
            if (!rst_n)
                od <= '0;
            else if (phi2)
                od <= ev;
        end
    end

endmodule

// File: tb/tb_latch_shreg_2ph_multi.sv
// Randomized scoreboard bench for latch_shreg_2ph_multi (2 lanes, 8 latches/lane):
// stimulus pushes predicted tap values and timing, a monitor checks them on shift_done.
module tb_latch_shreg_2ph_multi;
    localparam int W  = 2;
    localparam int D  = 8;
    localparam int DW = 8;
    localparam int H  = D / 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic [W-1:0]  din;
    logic [DW-1:0] div;
    logic [1:0]    tap_sel;
    logic [W-1:0]  dout;
    logic          phi1;
    logic          phi2;
    logic          busy;
    logic          shift_done;

    latch_shreg_2ph_multi #(.WIDTH(W), .DEPTH(D), .DIV_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din), .div(div),
        .tap_sel(tap_sel), .dout(dout), .phi1(phi1), .phi2(phi2), .busy(busy),
        .shift_done(shift_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           cyc;
        int           plen;
    } exp_t;

    exp_t         sb[$];
    logic [H-1:0] mdl [W];
    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int p1len  = 0;
    int p2len  = 0;
    int phi_hi = 0;
    int dones  = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: phase exclusivity every clock, and scoreboard pop on each strobe
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            p1len = 0;
            p2len = 0;
        end else begin
            chk("phi overlap", int'(phi1 & phi2), 0);
            if (phi1) p1len++;
            if (phi2) p2len++;
            if (phi1 || phi2) phi_hi++;
            if (shift_done) begin
                dones++;
                if (sb.size() == 0) begin
                    chk("unexpected shift_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("dout at shift_done", int'(dout), int'(e.d));
                    chk("shift_done cycle", cyc, e.cyc);
                    chk("phi1 length", p1len, e.plen);
                    chk("phi2 length", p2len, e.plen);
                end
                p1len = 0;
                p2len = 0;
            end
        end
    end

    // Issues one shift cycle starting at negedge+1 and returns at negedge+1 of the next boundary
    task automatic run_cycle(input logic [1:0] m, input logic [W-1:0] d, input int dv,
                             input int tp, input bit stop);
        int   len;
        exp_t e;
        len     = 2 * dv + 4;
        mode    = m;
        din     = d;
        div     = dv[DW-1:0];
        tap_sel = tp[1:0];
        en      = 1'b1;
        if (!m[1]) begin
            for (int l = 0; l < W; l++) begin
                logic b;
                b      = (m == 2'b01) ? mdl[l][tp] : d[l];
                mdl[l] = {mdl[l][H-2:0], b};
                e.d[l] = mdl[l][tp];
            end
            e.cyc  = cyc + len;
            e.plen = dv + 1;
            sb.push_back(e);
        end
        @(negedge clk); #1;
        mode = 2'($urandom);
        din  = W'($urandom);
        div  = DW'($urandom);
        if (stop) en = 1'b0;
        repeat (len - 1) @(negedge clk);
        #1;
        if (stop) en = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        repeat (2) @(negedge clk);
        #1;
        chk({nm, " busy"}, int'(busy), 0);
        chk({nm, " phi"}, int'(phi1 | phi2), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int hs_phi;
        int hs_done;
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        din     = '0;
        div     = '0;
        tap_sel = '0;
        for (int l = 0; l < W; l++) mdl[l] = '0;

        // Reset with random inputs
        repeat (3) begin
            @(negedge clk);
            mode    = 2'($urandom);
            din     = W'($urandom);
            div     = DW'($urandom);
            tap_sel = 2'($urandom);
            en      = 1'($urandom);
            #1;
            chk("reset dout", int'(dout), 0);
            chk("reset phi1", int'(phi1), 0);
            chk("reset phi2", int'(phi2), 0);
            chk("reset busy", int'(busy), 0);
            chk("reset shift_done", int'(shift_done), 0);
        end
        en = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Walk a single 1 through lane 0 to the last tap
        run_cycle(2'b00, 2'b01, 0, 3, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(2'b00, 2'b00, 0, 3, i == 2);
        check_idle("walk idle");
        @(negedge clk); #1;

        // First tap, div=3 (10-clk period)
        run_cycle(2'b00, 2'b11, 3, 0, 1'b0);
        run_cycle(2'b00, 2'b10, 3, 0, 1'b1);
        check_idle("tap idle");
        @(negedge clk); #1;

        // Load 1011 (lane 1 gets the complement), then recirculate from the last tap
        run_cycle(2'b00, 2'b01, 0, 3, 1'b0);
        run_cycle(2'b00, 2'b10, 0, 3, 1'b0);
        run_cycle(2'b00, 2'b01, 0, 3, 1'b0);
        run_cycle(2'b00, 2'b01, 1, 3, 1'b0);
        for (int i = 0; i < 8; i++) run_cycle(2'b01, 2'($urandom), i % 3, 3, 1'b0);

        // Hold cycles: no phases, no strobe, contents kept; then en dropped inside P1
        hs_phi  = phi_hi;
        hs_done = dones;
        for (int i = 0; i < 3; i++)
            run_cycle(2'b10 | 2'($urandom_range(0, 1)), 2'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0);
        chk("hold phi pulses", phi_hi - hs_phi, 0);
        chk("hold shift_done pulses", dones - hs_done, 0);
        run_cycle(2'b01, 2'b00, 2, 2, 1'b0);
        run_cycle(2'b00, 2'b11, 1, 1, 1'b1);
        check_idle("en drop idle");
        @(negedge clk); #1;

        // Fill with ones, then reset while in P2
        for (int i = 0; i < 4; i++) run_cycle(2'b00, 2'b11, 0, 3, 1'b0);
        mode    = 2'b00;
        din     = 2'b11;
        div     = 8'd3;
        tap_sel = 2'd0;
        en      = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("pre-reset in P2", int'(phi2), 1);
        chk("pre-reset dout loaded", int'(dout), 3);
        rst_n = 1'b0;
        #1;
        for (int tp = 0; tp < H; tp++) begin
            tap_sel = tp[1:0];
            #1;
            chk("mid-P2 reset dout", int'(dout), 0);
        end
        chk("mid-P2 reset phi2", int'(phi2), 0);
        chk("mid-P2 reset busy", int'(busy), 0);
        chk("mid-P2 reset shift_done", int'(shift_done), 0);
        for (int l = 0; l < W; l++) mdl[l] = '0;
        @(negedge clk); #1;
        en = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Random traffic after reset, including one maximum-divider cycle
        for (int i = 0; i < 30; i++) begin
            if (i == 10)
                run_cycle(2'b00, 2'($urandom), 255, $urandom_range(0, 3), 1'b0);
            else
                run_cycle(2'($urandom_range(0, 3)), 2'($urandom), $urandom_range(0, 4),
                          $urandom_range(0, 3), i == 29);
        end
        check_idle("final idle");
        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
